// File: rtl/vga_timing_pkg.sv
// Shared timing defaults and helpers for the VGA raster generator.
// Defaults describe 640x480@60 with negative sync pulses.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 10;

    function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int widthFor(input int n);
        return $clog2(n);
    endfunction

    localparam int DEF_H_TOTAL = axisTotal(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axisTotal(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping counter plus combinational sync/active/wrap decode.
// Used once for pixels within a line and once for lines within a frame.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0,
    parameter int CW     = DEF_CW
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    input  logic          i_tick,
    output logic [CW-1:0] count,
    output logic          sync,
    output logic          active,
    output logic          wrap
);

    localparam int TOTAL = axisTotal(ACTIVE, FP, SYNC, BP);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FP);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FP + SYNC - 1);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1 || CW < widthFor(TOTAL)) begin : g_param_check
        $error("vga_axis_counter: zero-width interval or counter too narrow for TOTAL");
    end

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_tick) begin
            count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign wrap   = (count_q == LAST);
    assign active = (count_q < ACT_END);
    assign sync   = ((count_q >= SYNC_FIRST) && (count_q <= SYNC_LAST)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: two axis counters feeding one rank of
// output registers, so position, sync, active and strobes all change together.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CW         = DEF_CW
) (
    input  logic          i_CLK,
    input  logic          i_RST,
    input  logic          i_CE,
    output logic          o_HSync,
    output logic          o_VSync,
    output logic          o_active,
    output logic [CW-1:0] o_x_pos,
    output logic [CW-1:0] o_y_pos,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_vblank_start
);

    localparam logic [CW-1:0] V_BLANK_LINE = CW'(V_ACTIVE);

    logic [CW-1:0] hCount, vCount;
    logic          hSync, vSync, hActive, vActive, hWrap, vWrapUnused;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL), .CW(CW)
    ) u_h (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_tick(i_CE),
        .count(hCount), .sync(hSync), .active(hActive), .wrap(hWrap)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL), .CW(CW)
    ) u_v (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_tick(i_CE && hWrap),
        .count(vCount), .sync(vSync), .active(vActive), .wrap(vWrapUnused)
    );

    logic [CW-1:0] xPos_q, xPos_d, yPos_q, yPos_d;
    logic          hSync_q, hSync_d, vSync_q, vSync_d, active_q, active_d;
    logic          lineStart_q, lineStart_d, frameStart_q, frameStart_d;
    logic          vblankStart_q, vblankStart_d;

    // Levels capture the counters only on pixel advances; strobes default low
    // so they last one clock regardless of i_CE.
    always_comb begin
        xPos_d        = xPos_q;
        yPos_d        = yPos_q;
        hSync_d       = hSync_q;
        vSync_d       = vSync_q;
        active_d      = active_q;
        lineStart_d   = 1'b0;
        frameStart_d  = 1'b0;
        vblankStart_d = 1'b0;
        if (i_CE) begin
            xPos_d        = hCount;
            yPos_d        = vCount;
            hSync_d       = hSync;
            vSync_d       = vSync;
            active_d      = hActive && vActive;
            lineStart_d   = (hCount == '0);
            frameStart_d  = (hCount == '0) && (vCount == '0);
            vblankStart_d = (hCount == '0) && (vCount == V_BLANK_LINE);
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            xPos_q        <= '0;
            yPos_q        <= '0;
            hSync_q       <= ~H_SYNC_POL;
            vSync_q       <= ~V_SYNC_POL;
            active_q      <= 1'b0;
            lineStart_q   <= 1'b0;
            frameStart_q  <= 1'b0;
            vblankStart_q <= 1'b0;
        end else begin
            xPos_q        <= xPos_d;
            yPos_q        <= yPos_d;
            hSync_q       <= hSync_d;
            vSync_q       <= vSync_d;
            active_q      <= active_d;
            lineStart_q   <= lineStart_d;
            frameStart_q  <= frameStart_d;
            vblankStart_q <= vblankStart_d;
        end
    end

    assign o_x_pos        = xPos_q;
    assign o_y_pos        = yPos_q;
    assign o_HSync        = hSync_q;
    assign o_VSync        = vSync_q;
    assign o_active       = active_q;
    assign o_line_start   = lineStart_q;
    assign o_frame_start  = frameStart_q;
    assign o_vblank_start = vblankStart_q;

endmodule
